// File: rtl/ov_capture_pkg.sv
// ---------------------------------------------------------------------------
// ov_capture_pkg
// Shared types and width helpers for the OV7670 pixel capture block.
//   capture_state_t : capture FSM states
//   clog2_min1      : $clog2 that never returns 0, so that a degenerate size
//                     of 1 still gives a legal one-bit vector
//   addr_width      : frame-buffer address width for a W x H frame
//   x_width/y_width : output coordinate widths
//   xcnt_width/
//   ycnt_width      : internal counter widths, wide enough to hold W and H
// ---------------------------------------------------------------------------
package ov_capture_pkg;

    typedef enum logic [1:0] {
        S_SYNC      = 2'd0,
        S_VBLANK    = 2'd1,
        S_LINE_WAIT = 2'd2,
        S_LINE      = 2'd3
    } capture_state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w == 32'd0) begin
            return 32'd1;
        end else begin
            return w;
        end
    endfunction

    function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
        return clog2_min1(w * h);
    endfunction

    function automatic int unsigned x_width(input int unsigned w);
        return clog2_min1(w);
    endfunction

    function automatic int unsigned y_width(input int unsigned h);
        return clog2_min1(h);
    endfunction

    function automatic int unsigned xcnt_width(input int unsigned w);
        return clog2_min1(w + 32'd1);
    endfunction

    function automatic int unsigned ycnt_width(input int unsigned h);
        return clog2_min1(h + 32'd1);
    endfunction

endpackage

// File: rtl/ov_pixel_capture_if.sv
// ---------------------------------------------------------------------------
// ov_pixel_capture_if
// Bundles the camera-side inputs and the pixel write-port outputs of
// ov_pixel_capture.
//   Camera side : EN, D[7:0], HREF, VSYNC
//   Pixel side  : o_PIXEL, DV, w_addr, o_X, o_Y, o_SOF, o_EOF, o_LINE_ERR,
//                 o_FRAME_COUNT[15:0]
// Modports: master = camera/stimulus side, slave = the capture block.
// ---------------------------------------------------------------------------
interface ov_pixel_capture_if
    import ov_capture_pkg::*;
#(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480,
    parameter int BYTES_PER_PIXEL   = 2
);
    localparam int AW = addr_width(RESOLUTION_WIDTH, RESOLUTION_HEIGHT);
    localparam int XW = x_width(RESOLUTION_WIDTH);
    localparam int YW = y_width(RESOLUTION_HEIGHT);

    logic                           EN;
    logic [7:0]                     D;
    logic                           HREF;
    logic                           VSYNC;

    logic [8*BYTES_PER_PIXEL-1:0]   o_PIXEL;
    logic                           DV;
    logic [AW-1:0]                  w_addr;
    logic [XW-1:0]                  o_X;
    logic [YW-1:0]                  o_Y;
    logic                           o_SOF;
    logic                           o_EOF;
    logic                           o_LINE_ERR;
    logic [15:0]                    o_FRAME_COUNT;

    modport master (
        output EN, D, HREF, VSYNC,
        input  o_PIXEL, DV, w_addr, o_X, o_Y, o_SOF, o_EOF, o_LINE_ERR, o_FRAME_COUNT
    );

    modport slave (
        input  EN, D, HREF, VSYNC,
        output o_PIXEL, DV, w_addr, o_X, o_Y, o_SOF, o_EOF, o_LINE_ERR, o_FRAME_COUNT
    );

endinterface

// File: rtl/ov_sync_edge.sv
// ---------------------------------------------------------------------------
// ov_sync_edge
// Registers HREF and VSYNC once and reports level, rising and falling edges.
// Edges compare the registered sample against the previous registered sample.
//   PCLK, RST           : clock, synchronous active-high reset
//   href_in, vsync_in   : raw camera sync lines
//   *_lvl/_rise/_fall   : registered level and single-cycle edge flags
// ---------------------------------------------------------------------------
module ov_sync_edge (
    input  logic PCLK,
    input  logic RST,
    input  logic href_in,
    input  logic vsync_in,
    output logic href_lvl,
    output logic href_rise,
    output logic href_fall,
    output logic vsync_lvl,
    output logic vsync_rise,
    output logic vsync_fall
);
    logic href_r;
    logic href_prev_r;
    logic vsync_r;
    logic vsync_prev_r;

    // Input sample plus one cycle of history for edge detection.
    always_ff @(posedge PCLK) begin
        if (RST) begin
            href_r       <= 1'b0;
            href_prev_r  <= 1'b0;
            vsync_r      <= 1'b0;
            vsync_prev_r <= 1'b0;
        end else begin
            href_r       <= href_in;
            href_prev_r  <= href_r;
            vsync_r      <= vsync_in;
            vsync_prev_r <= vsync_r;
        end
    end

    assign href_lvl   = href_r;
    assign href_rise  = href_r & ~href_prev_r;
    assign href_fall  = ~href_r & href_prev_r;
    assign vsync_lvl  = vsync_r;
    assign vsync_rise = vsync_r & ~vsync_prev_r;
    assign vsync_fall = ~vsync_r & vsync_prev_r;

endmodule

// File: rtl/ov_pixel_capture.sv
// ---------------------------------------------------------------------------
// ov_pixel_capture
// Converts the OV7670 byte stream into whole pixels of BYTES_PER_PIXEL bytes
// with frame-buffer address and x/y coordinates. Adds frame gating (EN,
// sampled at frame start), 1-of-N frame decimation, SOF/EOF strobes,
// line-length error detection and a captured-frame counter.
//   PCLK, RST : pixel clock, synchronous active-high reset
//   bus       : ov_pixel_capture_if.slave (camera inputs, pixel outputs)
// Output timing: the last byte of a pixel is registered at edge k, DV and the
// pixel data/position update at edge k+1. All outputs are registered.
// ---------------------------------------------------------------------------
module ov_pixel_capture
    import ov_capture_pkg::*;
#(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480,
    parameter int BYTES_PER_PIXEL   = 2,
    parameter bit MSB_FIRST         = 1'b1,
    parameter int FRAME_DECIMATION  = 1
) (
    input  logic PCLK,
    input  logic RST,
    ov_pixel_capture_if.slave bus
);
    localparam int W   = RESOLUTION_WIDTH;
    localparam int H   = RESOLUTION_HEIGHT;
    localparam int BPP = BYTES_PER_PIXEL;
    localparam int PW  = 8 * BPP;
    localparam int AW  = addr_width(W, H);
    localparam int XW  = x_width(W);
    localparam int YW  = y_width(H);
    localparam int XCW = xcnt_width(W);
    localparam int YCW = ycnt_width(H);
    localparam int BW  = clog2_min1(BPP);
    localparam int DW  = clog2_min1(FRAME_DECIMATION);

    localparam logic [BW-1:0]  LAST_BYTE = BW'(BPP - 1);
    localparam logic [XCW-1:0] W_CNT     = XCW'(W);
    localparam logic [YCW-1:0] H_CNT     = YCW'(H);
    localparam logic [AW-1:0]  W_ADDR    = AW'(W);
    localparam logic [DW-1:0]  DEC_LAST  = DW'(FRAME_DECIMATION - 1);

    // Edge detector outputs
    logic href_lvl_s, href_rise_s, href_fall_s;
    logic vsync_lvl_s, vsync_rise_s, vsync_fall_s;

    // Internal state
    logic [7:0]     d_r;
    capture_state_t state_r;
    logic [PW-1:0]  pix_r;
    logic [BW-1:0]  b_r;
    logic [XCW-1:0] x_r;
    logic [YCW-1:0] y_r;
    logic [AW-1:0]  addr_r;
    logic [AW-1:0]  row_base_r;
    logic           over_r;
    logic           capture_r;
    logic [DW-1:0]  dec_r;

    // Registered outputs
    logic           dv_r;
    logic [PW-1:0]  pixel_out_r;
    logic [AW-1:0]  addr_out_r;
    logic [XW-1:0]  x_out_r;
    logic [YW-1:0]  y_out_r;
    logic           sof_r;
    logic           eof_r;
    logic           line_err_r;
    logic [15:0]    frame_cnt_r;

    // Combinational helpers
    logic [BW-1:0]  byte_pos_s;
    logic [PW-1:0]  pixel_ins_s;
    logic           take_byte_s;
    logic           line_bad_s;

    ov_sync_edge u_sync (
        .PCLK       (PCLK),
        .RST        (RST),
        .href_in    (bus.HREF),
        .vsync_in   (bus.VSYNC),
        .href_lvl   (href_lvl_s),
        .href_rise  (href_rise_s),
        .href_fall  (href_fall_s),
        .vsync_lvl  (vsync_lvl_s),
        .vsync_rise (vsync_rise_s),
        .vsync_fall (vsync_fall_s)
    );

    // Data byte input register, aligned with the HREF/VSYNC samples.
    always_ff @(posedge PCLK) begin
        if (RST) begin
            d_r <= 8'd0;
        end else begin
            d_r <= bus.D;
        end
    end

    // Slot of the current byte inside the pixel word.
    always_comb begin
        if (MSB_FIRST) begin
            byte_pos_s = LAST_BYTE - b_r;
        end else begin
            byte_pos_s = b_r;
        end
    end

    // Pixel word with the current byte dropped into its slot.
    always_comb begin
        pixel_ins_s = pix_r;
        for (int i = 0; i < BPP; i++) begin
            pixel_ins_s[8*i +: 8] = (BW'(i) == byte_pos_s) ? d_r : pix_r[8*i +: 8];
        end
    end

    // A byte is consumed on the HREF rise (byte 0) and while HREF stays high;
    // a coincident VSYNC rise always takes priority over line data.
    always_comb begin
        take_byte_s = 1'b0;
        case (state_r)
            S_LINE_WAIT: take_byte_s = href_rise_s & ~vsync_rise_s;
            S_LINE:      take_byte_s = href_lvl_s & ~vsync_rise_s;
            default:     take_byte_s = 1'b0;
        endcase
    end

    // Line is malformed if it did not carry exactly W whole pixels.
    always_comb begin
        line_bad_s = (x_r != W_CNT) | over_r | (b_r != {BW{1'b0}});
    end

    // Capture FSM, pixel assembly, position counters and registered outputs.
    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_r     <= S_SYNC;
            pix_r       <= {PW{1'b0}};
            b_r         <= {BW{1'b0}};
            x_r         <= {XCW{1'b0}};
            y_r         <= {YCW{1'b0}};
            addr_r      <= {AW{1'b0}};
            row_base_r  <= {AW{1'b0}};
            over_r      <= 1'b0;
            capture_r   <= 1'b0;
            dec_r       <= {DW{1'b0}};
            dv_r        <= 1'b0;
            pixel_out_r <= {PW{1'b0}};
            addr_out_r  <= {AW{1'b0}};
            x_out_r     <= {XW{1'b0}};
            y_out_r     <= {YW{1'b0}};
            sof_r       <= 1'b0;
            eof_r       <= 1'b0;
            line_err_r  <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            dv_r       <= 1'b0;
            sof_r      <= 1'b0;
            eof_r      <= 1'b0;
            line_err_r <= 1'b0;

            case (state_r)
                S_SYNC: begin
                    // Only a VSYNC high phase can precede a clean frame start.
                    if (vsync_lvl_s) begin
                        state_r <= S_VBLANK;
                    end
                end

                S_VBLANK: begin
                    if (vsync_fall_s) begin
                        capture_r  <= bus.EN & (dec_r == {DW{1'b0}});
                        dec_r      <= (dec_r == DEC_LAST) ? {DW{1'b0}} : dec_r + DW'(1'b1);
                        x_r        <= {XCW{1'b0}};
                        y_r        <= {YCW{1'b0}};
                        b_r        <= {BW{1'b0}};
                        addr_r     <= {AW{1'b0}};
                        row_base_r <= {AW{1'b0}};
                        over_r     <= 1'b0;
                        state_r    <= S_LINE_WAIT;
                    end
                end

                S_LINE_WAIT: begin
                    if (vsync_rise_s) begin
                        state_r <= S_VBLANK;
                        eof_r   <= capture_r;
                        if (capture_r) begin
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                        end
                    end else if (href_rise_s) begin
                        state_r <= S_LINE;
                    end
                end

                S_LINE: begin
                    if (vsync_rise_s) begin
                        // Frame ends inside a line: an HREF still high means
                        // the line was cut short.
                        state_r    <= S_VBLANK;
                        eof_r      <= capture_r;
                        line_err_r <= capture_r & (href_lvl_s | line_bad_s);
                        if (capture_r) begin
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                        end
                    end else if (href_fall_s) begin
                        state_r    <= S_LINE_WAIT;
                        line_err_r <= capture_r & line_bad_s;
                        x_r        <= {XCW{1'b0}};
                        b_r        <= {BW{1'b0}};
                        over_r     <= 1'b0;
                        // Next row starts from the row base, so a short line
                        // does not shift the following rows.
                        if (y_r < H_CNT) begin
                            y_r        <= y_r + YCW'(1'b1);
                            row_base_r <= row_base_r + W_ADDR;
                            addr_r     <= row_base_r + W_ADDR;
                        end
                    end
                end

                default: begin
                    state_r <= S_SYNC;
                end
            endcase

            if (take_byte_s) begin
                pix_r <= pixel_ins_s;
                if (b_r == LAST_BYTE) begin
                    b_r <= {BW{1'b0}};
                    if (x_r < W_CNT) begin
                        x_r <= x_r + XCW'(1'b1);
                        if (y_r < H_CNT) begin
                            addr_r <= addr_r + AW'(1'b1);
                            if (capture_r) begin
                                dv_r        <= 1'b1;
                                pixel_out_r <= pixel_ins_s;
                                addr_out_r  <= addr_r;
                                x_out_r     <= x_r[XW-1:0];
                                y_out_r     <= y_r[YW-1:0];
                                sof_r       <= (x_r == {XCW{1'b0}}) && (y_r == {YCW{1'b0}});
                            end
                        end
                    end else begin
                        over_r <= 1'b1;
                    end
                end else begin
                    b_r <= b_r + BW'(1'b1);
                end
            end
        end
    end

    assign bus.DV            = dv_r;
    assign bus.o_PIXEL       = pixel_out_r;
    assign bus.w_addr        = addr_out_r;
    assign bus.o_X           = x_out_r;
    assign bus.o_Y           = y_out_r;
    assign bus.o_SOF         = sof_r;
    assign bus.o_EOF         = eof_r;
    assign bus.o_LINE_ERR    = line_err_r;
    assign bus.o_FRAME_COUNT = frame_cnt_r;

endmodule
